serial_adder_seq: RTL and testbench

Sequencer that time-shares one 1-bit full-adder cell (two half-adder stages plus carry OR) to add or subtract two WIDTH-bit operands bit-serially, LSB first.
- Accepts an operation via a valid/ready handshake, runs it over WIDTH clock cycles, then presents the result with a valid/ready handshake.
- Sits between the tile's input pins and the tile's output pins.
- Trades WIDTH-fold latency for a single shared adder cell.

---
 rtl/serial_adder_seq.sv | 112 +++++++++++
 tb/tb_serial_adder_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract sequencer: one shared full-adder cell processes
// a WIDTH-bit operation LSB first over WIDTH cycles, with valid/ready on both sides.
module serial_adder_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic w_a_i;
   logic w_b_i;
   logic w_h1_s;
   logic w_h1_c;
   logic w_h2_c;
   logic w_s;
   logic w_c_next;

   // Shared full-adder cell: two half-adders plus carry OR
   assign w_a_i    = r_a[0];
   assign w_b_i    = r_b[0];
   assign w_h1_s   = w_a_i ^ w_b_i;
   assign w_h1_c   = w_a_i & w_b_i;
   assign w_s      = w_h1_s ^ r_carry;
   assign w_h2_c   = w_h1_s & r_carry;
   assign w_c_next = w_h1_c | w_h2_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1: the +1 enters as the initial carry
                  r_a     <= a;
                  r_b     <= op_sub ? ~b : b;
                  r_carry <= op_sub;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_carry <= w_c_next;
               if (r_cnt == LAST_BIT) begin
                  r_cout  <= w_c_next;
                  r_ovf   <= r_carry ^ w_c_next;
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake flags decode directly from the state register
   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized self-checking bench for serial_adder_seq against an arithmetic
// reference model (integer add/subtract with signed range check).
module tb_serial_adder_seq;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   int n_checks;
   int n_errors;

   serial_adder_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op_sub   (op_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
      int unsigned ux, uy, t;
      int          sx, sy, r;
      logic [W-1:0] s;
      logic         c, v;
      ux = 32'(x);
      uy = 32'(y);
      sx = x[W-1] ? int'(ux) - (1 << W) : int'(ux);
      sy = y[W-1] ? int'(uy) - (1 << W) : int'(uy);
      if (sub) begin
         t = ux + (1 << W) - uy;
         r = sx - sy;
      end else begin
         t = ux + uy;
         r = sx + sy;
      end
      s = W'(t);
      c = ((t >> W) & 1) != 0;
      v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return {v, c, s};
   endfunction

   task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                           input string tag);
      @(negedge clk);
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = xa;
      b        = xb;
      op_sub   = xs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      op_sub   = 1'($urandom);
   endtask

   // Called #1 after the accept edge; waits (bounded) for out_valid
   task automatic wait_result(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                              input string tag);
      int          cyc;
      logic [W+1:0] e;
      e   = model(xa, xb, xs);
      cyc = 0;
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      check({tag, " in_ready in run"}, 32'(in_ready), 32'd0);
      while (!out_valid && cyc < int'(W) + 4) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(W));
      check({tag, " sum"}, 32'(sum), 32'(e[W-1:0]));
      check({tag, " cout"}, 32'(cout), 32'(e[W]));
      check({tag, " ovf"}, 32'(ovf), 32'(e[W+1]));
   endtask

   // Hold backpressure for n cycles with a competing request, then release
   task automatic drain(input int n, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input string tag);
      logic [W-1:0] hs;
      logic         hc, hv;
      hs = sum;
      hc = cout;
      hv = ovf;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
         check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
         check({tag, " hold result"}, {22'd0, hv, hc, hs}, {22'd0, ovf, cout, sum});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " result kept"}, {22'd0, hv, hc, hs}, {22'd0, ovf, cout, sum});
      if (n > 0) begin
         a = xa; b = xb; op_sub = xs;
      end
   endtask

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input int bp, input string tag);
      out_ready = (bp == 0);
      start_op(xa, xb, xs, tag);
      wait_result(xa, xb, xs, tag);
      drain(bp, xa, xb, xs, tag);
   endtask

   initial begin
      logic [W-1:0] na, nb;
      logic         ns;
      int           seen;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", {22'd0, ovf, cout, sum}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'h5A, 8'h3C, 1'b0, 0, "add_ovf");
      check("add_ovf directed", {22'd0, ovf, cout, sum}, {22'd0, 1'b1, 1'b0, 8'h96});
      run_op(8'hFF, 8'h01, 1'b0, 0, "wrap");
      check("wrap directed", {22'd0, ovf, cout, sum}, {22'd0, 1'b0, 1'b1, 8'h00});
      run_op(8'h10, 8'h20, 1'b1, 0, "borrow");
      check("borrow directed", {22'd0, ovf, cout, sum}, {22'd0, 1'b0, 1'b0, 8'hF0});
      run_op(8'h80, 8'h01, 1'b1, 0, "sub_ovf");
      check("sub_ovf directed", {22'd0, ovf, cout, sum}, {22'd0, 1'b1, 1'b1, 8'h7F});

      // Backpressure with a new request pending; it must be taken right after IDLE
      out_ready = 1'b0;
      start_op(8'h33, 8'h44, 1'b0, "bp");
      wait_result(8'h33, 8'h44, 1'b0, "bp");
      na = 8'hC8; nb = 8'h9D; ns = 1'b1;
      in_valid = 1'b1; a = na; b = nb; op_sub = ns;
      drain(5, na, nb, ns, "bp");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      out_ready = 1'b1;
      wait_result(na, nb, ns, "bp_next");
      @(posedge clk);
      #1;

      // Asynchronous reset three cycles into RUN
      start_op(8'h5A, 8'h3C, 1'b0, "rst_mid");
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid in_ready", 32'(in_ready), 32'd1);
      check("rst_mid busy", 32'(busy), 32'd0);
      check("rst_mid out_valid", 32'(out_valid), 32'd0);
      check("rst_mid result", {22'd0, ovf, cout, sum}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < int'(W) + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_mid no out_valid", 32'(seen), 32'd0);
      run_op(8'h01, 8'h02, 1'b0, 0, "after_rst");
      check("after_rst directed", {22'd0, ovf, cout, sum}, 32'h03);

      for (int k = 0; k < 40; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
